fft_stream_host: RTL

Host-side stream endpoint for the 64-point FFT processor. It holds a 64-sample frame written by the host and transmits it on the FFT serial input (`In_Stream`/`Data_Start`/`Mode`). It then receives the 64 result words qualified by `Data_Out` from `Out_Stream` into a result buffer the host can read back. It sits between the system bus logic and `fft_64p_16b_top`, and is the transmitter and receiver for that block's stream interface.

---
 rtl/fft_stream_host.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fft_stream_host.sv
// fft_stream_host: host-side stream endpoint for the 64-point FFT core.
// Buffers a host-written sample frame, streams it to the FFT serial input,
// then captures the 64 qualified result words into a host-readable buffer.
module fft_stream_host #(
  parameter int NPTS    = 64,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [5:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          mode_in,
  input  logic [5:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic          proto_err,
  output logic [DW-1:0] In_Stream,
  output logic          Data_Start,
  output logic          Mode,
  input  logic [DW-1:0] Out_Stream,
  input  logic          Data_Out
);

  localparam int          CW        = $clog2(TIMEOUT + 1);
  localparam logic [5:0]  K_LAST    = 6'(NPTS - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  // Sample and result storage; deliberately not reset so they map to RAM.
  logic [DW-1:0] sbuf [0:NPTS-1];
  logic [DW-1:0] rbuf [0:NPTS-1];

  state_t        state, state_next;
  logic [5:0]    k, k_next;
  logic [CW-1:0] idle, idle_next;
  logic          mode_next, busy_next, done_next;
  logic          timeout_next, proto_next, data_start_next;
  logic [DW-1:0] in_stream_next;
  logic          sbuf_we, rbuf_we;
  logic [5:0]    rbuf_waddr;
  logic [5:0]    k_inc;

  assign k_inc = k + 6'd1;

  // Host writes land in the sample buffer only while idle.
  always_ff @(posedge clk) begin
    if (sbuf_we) sbuf[wr_addr] <= wr_data;
  end

  // Captured result words from the FFT output stream.
  always_ff @(posedge clk) begin
    if (rbuf_we) rbuf[rbuf_waddr] <= Out_Stream;
  end

  // Registered host read port, usable in every state; old data on a same-edge write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= rbuf[rd_addr];
  end

  // State, index, idle counter and all stream/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      k           <= '0;
      idle        <= '0;
      Mode        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      Data_Start  <= 1'b0;
      In_Stream   <= '0;
    end else begin
      state       <= state_next;
      k           <= k_next;
      idle        <= idle_next;
      Mode        <= mode_next;
      busy        <= busy_next;
      done        <= done_next;
      timeout_err <= timeout_next;
      proto_err   <= proto_next;
      Data_Start  <= data_start_next;
      In_Stream   <= in_stream_next;
    end
  end

  // Frame sequencer: next state, counters and next values of the registered outputs.
  always_comb begin
    state_next      = state;
    k_next          = k;
    idle_next       = idle;
    mode_next       = Mode;
    busy_next       = busy;
    timeout_next    = timeout_err;
    proto_next      = proto_err;
    done_next       = 1'b0;
    data_start_next = 1'b0;
    in_stream_next  = '0;
    sbuf_we         = 1'b0;
    rbuf_we         = 1'b0;
    rbuf_waddr      = k;
    case (state)
      S_IDLE: begin
        sbuf_we = wr_en;
        if (start) begin
          state_next      = S_SEND;
          mode_next       = mode_in;
          timeout_next    = 1'b0;
          proto_next      = 1'b0;
          k_next          = '0;
          idle_next       = '0;
          busy_next       = 1'b1;
          data_start_next = 1'b1;
          // A write to word 0 on the start edge belongs to this frame.
          if (wr_en && (wr_addr == 6'd0)) in_stream_next = wr_data;
          else                            in_stream_next = sbuf[0];
        end
      end
      S_SEND: begin
        // k is the index currently on In_Stream; Data_Out here is a protocol violation.
        if (Data_Out) proto_next = 1'b1;
        if (k == K_LAST) begin
          state_next = S_WAIT;
          idle_next  = '0;
        end else begin
          k_next         = k_inc;
          in_stream_next = sbuf[k_inc];
        end
      end
      S_WAIT: begin
        if (Data_Out) begin
          rbuf_we    = 1'b1;
          rbuf_waddr = 6'd0;
          k_next     = 6'd1;
          idle_next  = '0;
          state_next = S_RECV;
        end else if (idle == IDLE_LAST) begin
          timeout_next = 1'b1;
          done_next    = 1'b1;
          state_next   = S_DONE;
        end else begin
          idle_next = idle + CW'(1);
        end
      end
      S_RECV: begin
        if (Data_Out) begin
          rbuf_we   = 1'b1;
          idle_next = '0;
          if (k == K_LAST) begin
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            k_next = k_inc;
          end
        end else if (idle == IDLE_LAST) begin
          timeout_next = 1'b1;
          done_next    = 1'b1;
          state_next   = S_DONE;
        end else begin
          idle_next = idle + CW'(1);
        end
      end
      S_DONE: begin
        busy_next  = 1'b0;
        k_next     = '0;
        state_next = S_IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        k_next     = '0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
